sm_bcd_converter: RTL and testbench

Sequential converter that takes a sign-and-magnitude result plus overflow flag from the arithmetic unit and produces signed BCD digits for the seven-segment display driver. It sits on the read side of the calculator datapath, between the arithmetic unit's answer and ovw outputs and the display multiplexer. It uses a start/ready/valid handshake and an iterative shift-add-3 (double dabble) engine, one magnitude bit per cycle.

---
 rtl/sm_bcd_pkg.sv | 15 +
 rtl/bcd_digit_adjust.sv | 18 +
 rtl/sm_bcd_converter.sv | 146 ++++++++++++++
 tb/tb_sm_bcd_converter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/sm_bcd_pkg.sv
// Shared types and constants for the sign-and-magnitude to BCD converter.
// State encoding, default widths and the BCD nibble width.
package sm_bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

    localparam int MAG_W_DEF  = 16;
    localparam int DIGITS_DEF = 5;
    localparam int NIB_W      = 4;

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble correction for one BCD nibble.
// Adds 3 to nibbles of 5 or more so the following shift carries correctly.
module bcd_digit_adjust
    import sm_bcd_pkg::*;
(
    input  logic [NIB_W-1:0] nib_i,
    output logic [NIB_W-1:0] nib_o
);

    // Add-3 correction ahead of the shift.
    always_comb begin
        nib_o = nib_i;
        if (nib_i >= 4'd5) begin
            nib_o = nib_i + 4'd3;
        end
    end

endmodule

// File: rtl/sm_bcd_converter.sv
// Iterative sign-and-magnitude to signed BCD converter, one bit per cycle.
// Optional leading-zero blank mask enabled by defining BCD_BLANK_EN.
module sm_bcd_converter
    import sm_bcd_pkg::*;
#(
    parameter int MAG_W  = MAG_W_DEF,
    parameter int DIGITS = DIGITS_DEF
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic [MAG_W:0]            value,
    input  logic                      ovw,
    output logic                      ready,
    output logic                      valid,
    output logic                      sign,
    output logic [NIB_W*DIGITS-1:0]   digits,
    output logic                      err
`ifdef BCD_BLANK_EN
    ,
    output logic [DIGITS-1:0]         blank
`endif
);

    localparam int BCD_W = NIB_W * DIGITS;
    localparam int CNT_W = $clog2(MAG_W + 1);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [MAG_W-1:0]   mag_q;
    logic [BCD_W-1:0]   bcd_q;
    logic               neg_q;

    logic               ready_q;
    logic               valid_q;
    logic               sign_q;
    logic               err_q;
    logic [BCD_W-1:0]   digits_q;

    logic [BCD_W-1:0]   adj;
    logic [BCD_W-1:0]   bcd_d;
    logic               last_shift;

    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        bcd_digit_adjust u_adj (
            .nib_i (bcd_q[i*NIB_W +: NIB_W]),
            .nib_o (adj[i*NIB_W +: NIB_W])
        );
    end

    assign bcd_d      = {adj[BCD_W-2:0], mag_q[MAG_W-1]};
    assign last_shift = (cnt_q == CNT_W'(MAG_W - 1));

`ifdef BCD_BLANK_EN
    logic [DIGITS-1:0] blank_d;
    logic [DIGITS-1:0] blank_q;
    logic              hz;

    // Mark digits that sit in the run of leading zeros; units never blank.
    always_comb begin
        blank_d = '0;
        hz      = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            hz         = hz & (bcd_d[i*NIB_W +: NIB_W] == '0);
            blank_d[i] = hz;
        end
    end

    assign blank = blank_q;
`endif

    // Control FSM, shift datapath and registered result outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mag_q    <= '0;
            bcd_q    <= '0;
            neg_q    <= 1'b0;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
            sign_q   <= 1'b0;
            err_q    <= 1'b0;
            digits_q <= '0;
`ifdef BCD_BLANK_EN
            blank_q  <= '0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        mag_q   <= value[MAG_W-1:0];
                        neg_q   <= value[MAG_W];
                        bcd_q   <= '0;
                        cnt_q   <= '0;
                        ready_q <= 1'b0;
                        if (ovw) begin
                            state_q  <= DONE;
                            valid_q  <= 1'b1;
                            digits_q <= '0;
                            sign_q   <= 1'b0;
                            err_q    <= 1'b1;
`ifdef BCD_BLANK_EN
                            blank_q  <= ~DIGITS'(1);
`endif
                        end else begin
                            state_q <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    bcd_q <= bcd_d;
                    mag_q <= {mag_q[MAG_W-2:0], 1'b0};
                    cnt_q <= cnt_q + 1'b1;
                    if (last_shift) begin
                        state_q  <= DONE;
                        valid_q  <= 1'b1;
                        digits_q <= bcd_d;
                        sign_q   <= neg_q & (|bcd_d);
                        err_q    <= 1'b0;
`ifdef BCD_BLANK_EN
                        blank_q  <= blank_d;
`endif
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign ready  = ready_q;
    assign valid  = valid_q;
    assign sign   = sign_q;
    assign err    = err_q;
    assign digits = digits_q;

endmodule

// File: tb/tb_sm_bcd_converter.sv
// Scoreboard bench for sm_bcd_converter (MAG_W=16, DIGITS=5).
// Stimulus pushes expected results; a monitor pops them on each valid pulse.
module tb_sm_bcd_converter;

    typedef struct {
        logic [19:0] digits;
        logic        sign;
        logic        err;
        logic [4:0]  blank;
    } exp_t;

    logic        clock;
    logic        reset;
    logic        start;
    logic [16:0] value;
    logic        ovw;
    logic        ready;
    logic        valid;
    logic        sign;
    logic [19:0] digits;
    logic        err;
`ifdef BCD_BLANK_EN
    logic [4:0]  blank;
`endif

    int n_pass;
    int n_total;
    exp_t sb[$];

    sm_bcd_converter #(
        .MAG_W  (16),
        .DIGITS (5)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .value  (value),
        .ovw    (ovw),
        .ready  (ready),
        .valid  (valid),
        .sign   (sign),
        .digits (digits),
        .err    (err)
`ifdef BCD_BLANK_EN
        ,
        .blank  (blank)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input bit ok, input string name,
                       input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endtask

    function automatic exp_t mk(input logic [19:0] d, input logic s,
                                input logic e, input logic [4:0] b);
        exp_t r;
        r.digits = d;
        r.sign   = s;
        r.err    = e;
        r.blank  = b;
        return r;
    endfunction

    // Monitor: every valid pulse must match the oldest pending expectation.
    always @(negedge clock) begin : mon
        exp_t e;
        if (valid) begin
            if (sb.size() == 0) begin
                chk(1'b0, "unexpected_valid", 32'(valid), 32'd0);
            end else begin
                e = sb.pop_front();
                chk(digits == e.digits, "digits", 32'(digits), 32'(e.digits));
                chk(sign == e.sign, "sign", 32'(sign), 32'(e.sign));
                chk(err == e.err, "err", 32'(err), 32'(e.err));
`ifdef BCD_BLANK_EN
                chk(blank == e.blank, "blank", 32'(blank), 32'(e.blank));
`endif
            end
        end
    end

    task automatic chk_reset(input string tag);
        chk(ready == 1'b1, {tag, "_ready"}, 32'(ready), 32'd1);
        chk(valid == 1'b0, {tag, "_valid"}, 32'(valid), 32'd0);
        chk(digits == 20'h0, {tag, "_digits"}, 32'(digits), 32'd0);
        chk(sign == 1'b0, {tag, "_sign"}, 32'(sign), 32'd0);
        chk(err == 1'b0, {tag, "_err"}, 32'(err), 32'd0);
`ifdef BCD_BLANK_EN
        chk(blank == 5'b0, {tag, "_blank"}, 32'(blank), 32'd0);
`endif
    endtask

    // Entered and left at a negedge; ready must be high on entry.
    task automatic conv(input logic [16:0] v, input logic o, input exp_t e,
                        input int lat, input bit inject);
        int  first_v;
        bit  busy_rdy;
        chk(ready == 1'b1, "ready_at_start", 32'(ready), 32'd1);
        start = 1'b1;
        value = v;
        ovw   = o;
        sb.push_back(e);
        @(posedge clock);
        #1;
        start = 1'b0;
        value = ~v;
        ovw   = 1'b0;
        first_v  = 0;
        busy_rdy = 1'b0;
        for (int k = 1; k <= lat + 1; k++) begin
            @(negedge clock);
            if (valid && first_v == 0) first_v = k;
            if (k <= lat && ready) busy_rdy = 1'b1;
            if (inject && k == 5) begin
                start = 1'b1;
                value = 17'h00999;
            end
            if (inject && k == 6) start = 1'b0;
            if (k == lat + 1) begin
                chk(ready == 1'b1, "ready_return", 32'(ready), 32'd1);
            end
        end
        chk(first_v == lat, "valid_latency", 32'(first_v), 32'(lat));
        chk(!busy_rdy, "ready_low_busy", 32'(busy_rdy), 32'd0);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        reset   = 1'b1;
        start   = 1'b0;
        value   = '0;
        ovw     = 1'b0;
        repeat (2) @(negedge clock);
        chk_reset("rst");
        reset = 1'b0;
        @(negedge clock);

        conv(17'h0007B, 1'b0, mk(20'h00123, 0, 0, 5'b11000), 17, 0);
        conv(17'h1FFFF, 1'b0, mk(20'h65535, 1, 0, 5'b00000), 17, 0);
        conv(17'h10000, 1'b0, mk(20'h00000, 0, 0, 5'b11110), 17, 0);
        conv(17'h12345, 1'b1, mk(20'h00000, 0, 1, 5'b11110), 1, 0);
        conv(17'h01234, 1'b0, mk(20'h04660, 0, 0, 5'b10000), 17, 1);
        conv(17'h09C40, 1'b0, mk(20'h40000, 0, 0, 5'b00000), 17, 0);
        conv(17'h10001, 1'b0, mk(20'h00001, 1, 0, 5'b11110), 17, 0);
        conv(17'h0000A, 1'b0, mk(20'h00010, 0, 0, 5'b11100), 17, 0);

        repeat (5) @(negedge clock);
        chk(digits == 20'h00010, "hold_digits", 32'(digits), 32'h10);

        start = 1'b1;
        value = 17'h0007B;
        ovw   = 1'b0;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (8) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk_reset("abort");
        reset = 1'b0;
        repeat (20) @(negedge clock);
        chk(ready == 1'b1, "idle_after_abort", 32'(ready), 32'd1);

        conv(17'h00009, 1'b0, mk(20'h00009, 0, 0, 5'b11110), 17, 0);

        repeat (5) @(negedge clock);
        chk(sb.size() == 0, "sb_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

endmodule
